waitstate_memory: RTL and testbench
===================================

Name: waitstate_memory

Overview:
- Parametrised successor to the single-cycle unified instruction/data memory of the multicycle core.
- Adds configurable read and write wait states, a request/ready handshake, registered read data, out-of-range and illegal-request error reporting, and file-based initial contents.
- Sits between the multicycle controller/datapath and storage, so the controller can model slow memory.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 16, address width in bits.
- DEPTH, 64, number of words; must satisfy DEPTH <= 2**ADDR_W.
- RD_WAIT, 2, extra wait cycles per read; 0 is legal.
- WR_WAIT, 1, extra wait cycles per write; 0 is legal.
- INIT_FILE, "", binary image loaded with $readmemb at time 0 when non-empty.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- address  in  ADDR_W  word address, sampled on request acceptance.
- wrdata  in  DATA_W  write data, sampled on request acceptance.
- mem_read  in  1  read request level.
- mem_write  in  1  write request level.
- dataout  out  DATA_W  registered read data.
- mem_ready  out  1  one-cycle completion pulse.
- mem_err  out  1  error flag; valid only while mem_ready is high.

Behaviour:
- FSM states: IDLE, BUSY, DONE, plus a wait counter (width sufficient for max(RD_WAIT, WR_WAIT)) and latched op/addr/data.
- Reset: on an rst edge, state goes to IDLE and mem_ready=0, mem_err=0, dataout=0, counter=0. Array contents are NOT cleared. rst dominates all other inputs.
- IDLE, neither request high: stay in IDLE.
- IDLE, exactly one request high and address < DEPTH: latch op, address and wrdata; load counter with RD_WAIT or WR_WAIT; go to BUSY.
- IDLE, both requests high, or address >= DEPTH (full ADDR_W compare): go to DONE with mem_err=1. No array access occurs and dataout is unchanged.
- BUSY, counter != 0: decrement and stay in BUSY.
- BUSY, counter == 0: perform the operation at this edge and go to DONE.
  - Read: dataout <= mem[latched addr].
  - Write: mem[latched addr] <= latched data.
- DONE: mem_ready=1 for exactly this cycle, with mem_err as set on entry. The FSM ignores requests here and unconditionally returns to IDLE.
- Latency: cycle 0 is the IDLE cycle that accepts the request. mem_ready is high in cycle 2+WAIT for a legal access, and in cycle 1 for an error.
- mem_ready and mem_err are low in all states except DONE.
- dataout holds its value until the next successful read completes; writes and errors do not change it.
- Address and wrdata changes after acceptance are ignored.
- Requester contract: drop the request by the edge ending the DONE cycle. A request still held in the following IDLE cycle is accepted as a new transaction.
- A write followed by a read to the same address returns the new data, because the write commits before DONE.
- Reset mid-operation: the transaction is aborted and no mem_ready is produced. A write is not committed if rst is high in its final BUSY cycle.
- No combinational paths from inputs to outputs.

Test Plan:
- Write, then read back (defaults): write 0xBEEF to addr 20 accepted in cycle 0 -> mem_ready=1, mem_err=0 in cycle 3. Read addr 20 accepted at its cycle 0 -> mem_ready in cycle 4, dataout=0xBEEF held afterwards.
- Out-of-range address: read addr 64 with DEPTH=64 -> mem_ready=1, mem_err=1 in cycle 1. dataout keeps 0xBEEF, and a subsequent read of addr 0 returns its prior value.
- Illegal request: mem_read=mem_write=1, addr 5, wrdata 0x1234 -> mem_ready=1, mem_err=1 in cycle 1. mem[5] is unchanged when read back.
- Reset during a read: assert rst in cycle 2 of a read of addr 20 -> no mem_ready pulse, dataout=0 from the cycle after rst, FSM idle. The next read of addr 20 still returns 0xBEEF.
- Reset during a write: with WR_WAIT=1, write 0x5555 to addr 21 and assert rst in cycle 2 (the final BUSY cycle) -> no commit; a read of addr 21 returns the old value.
- Zero-wait parameterisation (RD_WAIT=0, WR_WAIT=0) with a request held continuously: read addr 20 -> mem_ready pulses in cycles 2, 5, 8, ..., one per transaction, never on consecutive cycles.

Source files
------------

// File: rtl/waitstate_memory.sv
// waitstate_memory: word memory with configurable read/write wait states, ready handshake and error reporting
module waitstate_memory #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 64,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1,
  parameter INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wrdata,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] dataout,
  output logic              mem_ready,
  output logic              mem_err
);
  localparam int MAXW = RD_WAIT > WR_WAIT ? RD_WAIT : WR_WAIT;
  localparam int CW = MAXW < 1 ? 1 : $clog2(MAXW + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [AW-1:0] a;
  logic [DATA_W-1:0] d;
  logic op_wr;
  logic in_range;
  assign in_range = {1'b0, address} < (ADDR_W + 1)'(DEPTH);
  always_ff @(posedge clk)
    if (!rst && state == BUSY && cnt == '0 && op_wr) mem[a] <= d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_ready <= 1'b0;
      mem_err <= 1'b0;
      dataout <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          mem_err <= 1'b0;
          if ((mem_read ^ mem_write) && in_range) begin
            op_wr <= mem_write;
            a <= address[AW-1:0];
            d <= wrdata;
            cnt <= mem_write ? CW'(WR_WAIT) : CW'(RD_WAIT);
            state <= BUSY;
          end else if (mem_read || mem_write) begin
            mem_ready <= 1'b1;
            mem_err <= 1'b1;
            state <= DONE;
          end
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            if (!op_wr) dataout <= mem[a];
            mem_ready <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          mem_ready <= 1'b0;
          mem_err <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_waitstate_memory.sv
// tb_waitstate_memory: transaction-timing model plus directed literal checks for waitstate_memory
module tb_waitstate_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] address = '0, wrdata = '0;
  logic mem_read = 1'b0, mem_write = 1'b0;
  logic [15:0] dataout;
  logic mem_ready, mem_err;
  logic [15:0] a0 = '0, d0 = '0;
  logic r0 = 1'b0, w0 = 1'b0;
  logic [15:0] dout0;
  logic ready0, err0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  waitstate_memory dut (
    .clk(clk), .rst(rst), .address(address), .wrdata(wrdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .dataout(dataout), .mem_ready(mem_ready), .mem_err(mem_err)
  );

  waitstate_memory #(.RD_WAIT(0), .WR_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .address(a0), .wrdata(d0),
    .mem_read(r0), .mem_write(w0),
    .dataout(dout0), .mem_ready(ready0), .mem_err(err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  int cyc = 0, cur, next_free = 0, done = -10, p_a = 0;
  logic p_wr = 1'b0, p_err = 1'b0, dout_known = 1'b1;
  logic [15:0] p_d = '0, exp_dout = '0;
  int mem_m [64];
  initial foreach (mem_m[i]) mem_m[i] = -1;

  always @(posedge clk) begin
    cur = cyc;
    if (rst) begin
      next_free = cur + 1;
      done = -10;
      exp_dout = '0;
      dout_known = 1'b1;
    end else begin
      if (cur == done - 1 && !p_err) begin
        if (p_wr) mem_m[p_a] = int'(p_d);
        else begin
          dout_known = mem_m[p_a] >= 0;
          exp_dout = 16'(mem_m[p_a]);
        end
      end
      if (cur >= next_free && (mem_read || mem_write)) begin
        if ((mem_read ^ mem_write) && address < 16'd64) begin
          p_err = 1'b0;
          p_wr = mem_write;
          p_a = int'(address);
          p_d = wrdata;
          done = cur + 2 + (mem_write ? 1 : 2);
        end else begin
          p_err = 1'b1;
          done = cur + 1;
        end
        next_free = done + 1;
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("model ready", mem_ready, cyc == done);
      chk("model err", mem_err, cyc == done && p_err);
      if (dout_known) chk("model dataout", dataout, exp_dout);
    end
  end

  task automatic op(input string name, input logic r, input logic w, input logic [15:0] a,
                    input logic [15:0] d, input int lat, input logic err);
    int got = -1;
    mem_read = r; mem_write = w; address = a; wrdata = d;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    address = 16'($urandom); wrdata = 16'($urandom);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_ready) begin
        got = n;
        break;
      end
    end
    chk({name, " latency"}, got, lat);
    chk({name, " err"}, mem_err, err);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", mem_ready, 1'b0);
    chk("reset err", mem_err, 1'b0);
    chk("reset dataout", dataout, 16'h0000);
    rst = 1'b0;
    op("wr0", 1'b0, 1'b1, 16'd0, 16'h0A0A, 3, 1'b0);
    op("wr5", 1'b0, 1'b1, 16'd5, 16'h0055, 3, 1'b0);
    op("wr21", 1'b0, 1'b1, 16'd21, 16'h00A1, 3, 1'b0);
    op("wr20", 1'b0, 1'b1, 16'd20, 16'hBEEF, 3, 1'b0);
    op("rd20", 1'b1, 1'b0, 16'd20, 16'h0000, 4, 1'b0);
    chk("rd20 data", dataout, 16'hBEEF);
    op("rd64", 1'b1, 1'b0, 16'd64, 16'h0000, 1, 1'b1);
    chk("rd64 keeps data", dataout, 16'hBEEF);
    op("rdffff", 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1, 1'b1);
    op("wr64", 1'b0, 1'b1, 16'd64, 16'h7777, 1, 1'b1);
    op("rd0", 1'b1, 1'b0, 16'd0, 16'h0000, 4, 1'b0);
    chk("rd0 data", dataout, 16'h0A0A);
    op("illegal", 1'b1, 1'b1, 16'd5, 16'h1234, 1, 1'b1);
    chk("illegal keeps data", dataout, 16'h0A0A);
    op("rd5", 1'b1, 1'b0, 16'd5, 16'h0000, 4, 1'b0);
    chk("rd5 data", dataout, 16'h0055);
    mem_read = 1'b1; address = 16'd20;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst mid read dataout", dataout, 16'h0000);
    chk("rst mid read ready", mem_ready, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    op("rd20 after rst", 1'b1, 1'b0, 16'd20, 16'h0000, 4, 1'b0);
    chk("rd20 after rst data", dataout, 16'hBEEF);
    mem_write = 1'b1; address = 16'd21; wrdata = 16'h5555;
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    op("rd21", 1'b1, 1'b0, 16'd21, 16'h0000, 4, 1'b0);
    chk("rd21 not committed", dataout, 16'h00A1);
    op("wr63", 1'b0, 1'b1, 16'd63, 16'hC0DE, 3, 1'b0);
    op("rd63", 1'b1, 1'b0, 16'd63, 16'h0000, 4, 1'b0);
    chk("rd63 data", dataout, 16'hC0DE);
    w0 = 1'b1; a0 = 16'd20; d0 = 16'hBEEF;
    @(posedge clk); #1;
    w0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    r0 = 1'b1; a0 = 16'd20;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("zw ready k=%0d", k), ready0, (k % 3) == 2);
      if (k % 3 == 2) begin
        chk($sformatf("zw data k=%0d", k), dout0, 16'hBEEF);
        chk($sformatf("zw err k=%0d", k), err0, 1'b0);
      end
    end
    r0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
